// File: rtl/fsk_frame_decoder_if.sv
// Bit-stream and decoded-word bundle for fsk_frame_decoder.
// master drives recovered bits and observes decoded words; slave is the decoder.
interface fsk_frame_decoder_if #(
  parameter int DATA_W = 4
);
  logic              bit_in;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic [7:0]        frame_cnt;

  modport master (
    output bit_in, bit_en,
    input  data_out, data_valid, parity_err, frame_cnt
  );

  modport slave (
    input  bit_in, bit_en,
    output data_out, data_valid, parity_err, frame_cnt
  );
endinterface

// File: rtl/fsk_frame_decoder.sv
// Serial frame decoder: header hunt, LSB-first payload capture, optional parity bit.
// Define FSK_DEC_PARITY_EN to append and check a parity bit after the payload.
module fsk_frame_decoder #(
  parameter int                  DATA_W     = 4,
  parameter int                  HEAD_LEN   = 3,
  parameter logic [HEAD_LEN-1:0] HEAD_PAT   = {HEAD_LEN{1'b1}},
  parameter bit                  ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  fsk_frame_decoder_if.slave bus
);
  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef FSK_DEC_PARITY_EN
  typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;
`else
  typedef enum logic [0:0] {HUNT, DATA} state_t;
`endif

  state_t              state_reg, state_next;
  logic [HEAD_LEN-1:0] hdr_sr_reg, hdr_sr_next, hdr_shift;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]   capture_reg, capture_next, capture_ins;
  logic [DATA_W-1:0]   data_out_reg, data_out_next;
  logic                data_valid_reg, data_valid_next;
  logic                parity_err_reg, parity_err_next;
  logic [7:0]          frame_cnt_reg, frame_cnt_next;

  assign hdr_shift = {hdr_sr_reg[HEAD_LEN-2:0], bus.bit_in};

  // Capture register with the incoming bit dropped into slot bit_cnt.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ins
      assign capture_ins[gi] = (bit_cnt_reg == CNT_W'(gi)) ? bus.bit_in : capture_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= HUNT;
      hdr_sr_reg     <= '0;
      bit_cnt_reg    <= '0;
      capture_reg    <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_cnt_reg  <= 8'd0;
    end else begin
      state_reg      <= state_next;
      hdr_sr_reg     <= hdr_sr_next;
      bit_cnt_reg    <= bit_cnt_next;
      capture_reg    <= capture_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      parity_err_reg <= parity_err_next;
      frame_cnt_reg  <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hdr_sr_next     = hdr_sr_reg;
    bit_cnt_next    = bit_cnt_reg;
    capture_next    = capture_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    parity_err_next = parity_err_reg;
    frame_cnt_next  = frame_cnt_reg;
    if (bus.bit_en) begin
      case (state_reg)
        HUNT: begin
          hdr_sr_next = hdr_shift;
          if (hdr_shift == HEAD_PAT) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            capture_next = '0;
          end
        end
        DATA: begin
          capture_next = capture_ins;
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
`ifdef FSK_DEC_PARITY_EN
            state_next = PAR;
`else
            // Completion; clearing hdr_sr keeps payload bits out of the next header.
            state_next      = HUNT;
            hdr_sr_next     = '0;
            data_out_next   = capture_ins;
            data_valid_next = 1'b1;
            frame_cnt_next  = frame_cnt_reg + 8'd1;
`endif
          end
        end
`ifdef FSK_DEC_PARITY_EN
        PAR: begin
          state_next      = HUNT;
          hdr_sr_next     = '0;
          data_out_next   = capture_reg;
          data_valid_next = 1'b1;
          parity_err_next = (^capture_reg) ^ bus.bit_in ^ ODD_PARITY;
          frame_cnt_next  = frame_cnt_reg + 8'd1;
        end
`endif
        default: state_next = HUNT;
      endcase
    end
  end

`ifndef FSK_DEC_PARITY_EN
  logic unused_odd_parity;
  assign unused_odd_parity = ODD_PARITY;
`endif

  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.parity_err = parity_err_reg;
  assign bus.frame_cnt  = frame_cnt_reg;
endmodule

// File: doc/fsk_frame_decoder.md
# fsk_frame_decoder

Parametrised serial frame decoder for the FSK receive path. Sits after the demodulator / bit slicer, accepts one recovered bit per bit-enable strobe, hunts for a fixed header pattern, then captures a DATA_W-bit payload and an optional parity bit. Presents each completed word with a one-cycle valid strobe, a parity-error flag and a running frame count.

## Interface
- DATA_W, 4: payload bits per frame, at least 1.
- HEAD_LEN, 3: header length in bits, 2 to 8.
- HEAD_PAT, {HEAD_LEN{1'b1}}: header pattern. MSB is the first received bit.
- ODD_PARITY, 0: 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bit_in  in  1  recovered serial bit.
- bit_en  in  1  sample strobe. bit_in is consumed only on edges where bit_en=1.
- data_out  out  DATA_W  last completed payload. Bit i is the i-th received data bit (LSB first).
- data_valid  out  1  one-cycle pulse: data_out, parity_err and frame_cnt were just updated.
- parity_err  out  1  parity result of the last frame (1 = mismatch).
- frame_cnt  out  8  count of completed frames, wraps.

## Operation
- FSM states: HUNT, DATA, PAR.
- HUNT
  - On each enabled bit: hdr_sr <= {hdr_sr[HEAD_LEN-2:0], bit_in}.
  - If the new value equals HEAD_PAT: go to DATA, bit_cnt <= 0.
- DATA
  - On each enabled bit: shift bit into the capture register at position bit_cnt, bit_cnt++.
  - On bit DATA_W-1: go to PAR if parity is compiled in; otherwise complete the frame and go to HUNT.
  - Header matching is suspended in DATA; payload bits never retrigger the header match.
- PAR
  - On the enabled bit: x = XOR of all captured bits and the parity bit.
  - parity_err <= x ^ ODD_PARITY.
  - Complete the frame, go to HUNT.
- Frame completion
  - data_out <= capture register.
  - data_valid pulses.
  - frame_cnt <= frame_cnt+1 (255 wraps to 0).
  - hdr_sr cleared to 0. A new header must consist entirely of bits received after the frame; header bits never overlap the previous frame.
- data_out and parity_err hold their values between frames. Partial frames never alter them.
- bit_en=0 on an edge: no state, counter or register change; data_valid=0.
- Reset (reset=0), at any time including mid-frame, takes effect immediately:
  - state=HUNT, hdr_sr=0, bit_cnt=0, capture=0.
  - data_out=0, data_valid=0, parity_err=0, frame_cnt=0.
  - The partial frame is discarded.

## Timing
- bit_in is sampled on the rising clk edge where bit_en=1. bit_en may be asserted on consecutive cycles.
- Header lock occurs at the edge sampling the last header bit. The next enabled bit is data bit 0.
- data_valid is registered: high for exactly one cycle, starting at the edge that samples the final frame bit (parity bit, or data bit DATA_W-1 without parity).
- data_out, parity_err and frame_cnt change on that same edge.
- Minimum frame spacing: HEAD_LEN + DATA_W (+1) enabled bits. No back-to-back pipelining beyond this.
- All outputs come directly from registers.

## Configuration
- FSK_DEC_PARITY_EN defined:
  - Frame is header + DATA_W data bits + 1 parity bit.
  - PAR state and parity_err logic are present.
- FSK_DEC_PARITY_EN undefined:
  - Frame is header + DATA_W data bits only.
  - PAR state is removed.
  - parity_err is tied to 0.
  - Completion occurs on data bit DATA_W-1.

## Test plan
- Defaults, macro on, bit_en=1 continuously. Stream 1,1,1, 1,0,1,0, 0.
  - Expect data_valid high for 1 cycle at the parity-bit edge.
  - data_out=4'b0101, parity_err=0, frame_cnt=1.
- Same frame, but parity bit = 1.
  - Expect parity_err=1, data_out=4'b0101, frame_cnt=2.
  - With ODD_PARITY=1, the same frame gives parity_err=0.
- bit_en pulsed one cycle in every three; frame 1,1,1, 1,1,1,1, 0. Idle cycles are inserted between bits.
  - Expect one data_valid, data_out=4'hF, parity_err=0.
  - Payload 1s do not retrigger the header.
- Noise then frame: stream 1,1,0, 1,1,1, 0,0,1,1, 0.
  - Expect lock only after the 6th bit.
  - data_out=4'b1100, parity_err=0, a single data_valid.
- Assert reset for 1 cycle after 2 data bits, then send the full frame from scenario 1.
  - Expect all outputs 0 immediately on reset and no data_valid for the aborted frame.
  - Then data_out=4'b0101, frame_cnt=1.
- Macro off. Stream 1,1,1, 0,1,1,0.
  - Expect data_valid at the 4th data-bit edge, data_out=4'b0110, parity_err=0.
  - The next bit 1 is treated as header-hunt input.
